// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped UART transmitter with byte FIFO, DATA/STATUS registers
module uart_tx_mmio #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        select,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [15:0] address,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        tx
);

    localparam int unsigned AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0] BIT_LAST   = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   rdata_q, rdata_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic        hit_data, hit_status;
    logic        fifo_empty, fifo_full;
    logic        push_req, push, pop;
    logic        busy, timer_done;
    logic [15:0] status;
    logic        unused_hi_bits;

    assign unused_hi_bits = ^write_data[15:8];

    assign hit_data   = select && (address == BASE_ADDR);
    assign hit_status = select && (address == BASE_ADDR + 16'd1);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_COUNT);
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    assign push_req   = write_enable && hit_data;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign push       = push_req && (!fifo_full || pop);
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign status     = {8'h00, 5'(count_q), ovf_q, fifo_full, busy};
    assign timer_done = (timer_q == BIT_LAST);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        rdata_d  = rdata_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        if (read_enable && hit_status) begin
            rdata_d = status;
            ovf_d   = 1'b0;
        end else if (read_enable && hit_data) begin
            rdata_d = 16'h0000;
        end
        if (push_req && !push) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    shift_d   = mem_q[rd_ptr_q];
                    timer_d   = 16'd0;
                    bit_idx_d = 3'd0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (timer_done) begin
                    timer_d = 16'd0;
                    state_d = S_DATA;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_DATA: begin
                if (timer_done) begin
                    timer_d = 16'd0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_STOP: begin
                if (timer_done) begin
                    timer_d = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Line level follows the state being entered so tx leaves a flop.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            rdata_q   <= 16'h0000;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= write_data[7:0];
        end
    end

    assign read_data = rdata_q;
    assign tx        = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - directed bench for uart_tx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=4)
module tb_uart_tx_mmio;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        select = 1'b0;
    logic        read_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [15:0] write_data = 16'h0000;
    logic [15:0] read_data;
    logic        tx;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit mon_en = 1'b1;

    logic [7:0] rx_q [$];
    int         rx_t [$];
    int         rx_bad = 0;

    logic [7:0] burst [6] = '{8'hA1, 8'h3C, 8'h0F, 8'hF0, 8'h96, 8'h77};
    logic [7:0] exp_rx [8] = '{8'h55, 8'hA1, 8'h3C, 8'h0F, 8'hF0, 8'h96, 8'h5A, 8'hC3};

    uart_tx_mmio #(
        .CLKS_PER_BIT(4),
        .BASE_ADDR   (16'hFF00),
        .FIFO_DEPTH  (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .select      (select),
        .read_enable (read_enable),
        .write_enable(write_enable),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .tx          (tx)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the access is sampled by the next posedge; returns at the following negedge.
    task automatic bus_op(input bit sel, input bit rd, input bit wr,
                          input logic [15:0] addr, input logic [15:0] data);
        select       = sel;
        read_enable  = rd;
        write_enable = wr;
        address      = addr;
        write_data   = data;
        @(negedge clock);
        select       = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        address      = 16'h0000;
        write_data   = 16'h0000;
    endtask

    // Serial decoder: mid-bit sampling, records byte and detection cycle.
    initial begin
        logic [7:0] b;
        int         t0;
        forever begin
            @(negedge clock);
            if (mon_en && !reset && tx == 1'b0) begin
                t0 = cyc;
                repeat (2) @(negedge clock);
                if (tx !== 1'b0) rx_bad++;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clock);
                    b[i] = tx;
                end
                repeat (4) @(negedge clock);
                if (tx !== 1'b1) rx_bad++;
                rx_q.push_back(b);
                rx_t.push_back(t0);
            end
        end
    end

    initial begin
        int low_cnt;
        logic exp_bit;
        logic [7:0] byte55;

        // Reset with a bus write held: must be ignored.
        select = 1'b1; write_enable = 1'b1; address = 16'hFF00; write_data = 16'h00AA;
        repeat (3) @(negedge clock);
        check_eq("reset tx", 32'(tx), 32'd1);
        check_eq("reset read_data", 32'(read_data), 32'h0000);
        reset = 1'b0; select = 1'b0; write_enable = 1'b0; address = 16'h0000; write_data = 16'h0000;
        bus_op(1, 1, 0, 16'hFF01, 16'h0000);
        check_eq("status after reset", 32'(read_data), 32'h0000);

        // Non-hits: deselected and out-of-range address.
        bus_op(0, 0, 1, 16'hFF00, 16'h0011);
        bus_op(1, 0, 1, 16'hFF02, 16'h0022);
        repeat (3) @(negedge clock);
        check_eq("no-hit tx idle", 32'(tx), 32'd1);
        bus_op(1, 1, 0, 16'hFF01, 16'h0000);
        check_eq("no-hit status", 32'(read_data), 32'h0000);

        // Single frame, checked cycle by cycle.
        byte55 = 8'h55;
        bus_op(1, 0, 1, 16'hFF00, 16'h1255);
        for (int k = 1; k <= 41; k++) begin
            @(negedge clock);
            if (k <= 4)       exp_bit = 1'b0;
            else if (k <= 36) exp_bit = byte55[(k - 5) / 4];
            else              exp_bit = 1'b1;
            check_eq($sformatf("frame55 cyc%0d", k), 32'(tx), 32'(exp_bit));
        end
        bus_op(1, 1, 0, 16'hFF01, 16'h0000);
        check_eq("status after frame", 32'(read_data), 32'h0000);

        // Burst of 6 writes: 1 in flight, 4 queued, 6th dropped.
        for (int i = 0; i < 6; i++) bus_op(1, 0, 1, 16'hFF00, {8'hEE, burst[i]});
        bus_op(1, 1, 0, 16'hFF01, 16'h0000);
        check_eq("status full+ovf", 32'(read_data), 32'h0027);
        bus_op(1, 1, 0, 16'hFF01, 16'h0000);
        check_eq("status ovf cleared", 32'(read_data), 32'h0023);
        // Land the next write on the edge where IDLE pops from the full FIFO.
        repeat (34) @(negedge clock);
        bus_op(1, 0, 1, 16'hFF00, 16'h005A);
        bus_op(1, 1, 0, 16'hFF01, 16'h0000);
        check_eq("status push-on-pop", 32'(read_data), 32'h0023);
        bus_op(1, 1, 0, 16'hFF02, 16'h0000);
        check_eq("read FF02 unchanged", 32'(read_data), 32'h0023);
        bus_op(0, 1, 0, 16'hFF01, 16'h0000);
        check_eq("read desel unchanged", 32'(read_data), 32'h0023);
        bus_op(1, 1, 0, 16'hFF00, 16'h0000);
        check_eq("read DATA", 32'(read_data), 32'h0000);

        for (int k = 0; k < 600 && rx_q.size() < 7; k++) @(negedge clock);
        check_eq("frames after burst", 32'(rx_q.size()), 32'd7);
        repeat (5) @(negedge clock);
        bus_op(1, 1, 0, 16'hFF01, 16'h0000);
        check_eq("status drained", 32'(read_data), 32'h0000);

        // Simultaneous read and write of DATA.
        bus_op(1, 1, 1, 16'hFF00, 16'h00C3);
        check_eq("rw DATA read", 32'(read_data), 32'h0000);
        bus_op(1, 1, 0, 16'hFF01, 16'h0000);
        check_eq("status after rw", 32'(read_data), 32'h0009);
        for (int k = 0; k < 200 && rx_q.size() < 8; k++) @(negedge clock);
        check_eq("frames total", 32'(rx_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) check_eq($sformatf("rx byte %0d", i), 32'(rx_q[i]), 32'(exp_rx[i]));
        for (int i = 2; i <= 6; i++) check_eq($sformatf("frame gap %0d", i), 32'(rx_t[i] - rx_t[i-1]), 32'd41);
        check_eq("start/stop levels", 32'(rx_bad), 32'd0);
        repeat (5) @(negedge clock);

        // Reset mid-frame at frame cycle 15 with a second byte queued.
        mon_en = 1'b0;
        bus_op(1, 0, 1, 16'hFF00, 16'h0000);
        bus_op(1, 0, 1, 16'hFF00, 16'h0000);
        repeat (14) @(negedge clock);
        check_eq("mid-frame tx low", 32'(tx), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("tx after reset", 32'(tx), 32'd1);
        low_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (tx !== 1'b1) low_cnt++;
        end
        check_eq("no frame after reset", 32'(low_cnt), 32'd0);
        bus_op(1, 1, 0, 16'hFF01, 16'h0000);
        check_eq("status after abort", 32'(read_data), 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
